// File: rtl/sr_readback_ctrl.sv
// Readback controller for the configuration shift register: capture, serial sample, parallel present.
// Optional compare against an expected word when SR_READBACK_CMP_EN is defined.
module sr_readback_ctrl #(
    parameter int DATA_WIDTH      = 170,
    parameter int CNT_WIDTH       = 8,
    parameter int SHIFT_DIRECTION = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sr_din,
`ifdef SR_READBACK_CMP_EN
    input  logic [DATA_WIDTH-1:0] expected,
    output logic                  mismatch,
`endif
    output logic                  capture_sr,
    output logic                  shift_en,
    output logic                  busy,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] dout
);

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        CAPTURE = 4'b0010,
        SHIFT   = 4'b0100,
        DONE    = 4'b1000
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                state;
    logic [CNT_WIDTH-1:0]  count;
    // Only W-1 bits of history are kept; the bit sampled on the final edge completes the word.
    logic [DATA_WIDTH-2:0] shift_q;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-2:0] shift_d;

    always_comb begin
        word    = '0;
        shift_d = '0;
        if (SHIFT_DIRECTION != 0) begin
            word    = {shift_q, sr_din};
            shift_d = word[DATA_WIDTH-2:0];
        end else begin
            word    = {sr_din, shift_q};
            shift_d = word[DATA_WIDTH-1:1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            shift_q    <= '0;
            dout       <= '0;
            capture_sr <= 1'b0;
            shift_en   <= 1'b0;
            busy       <= 1'b0;
            valid      <= 1'b0;
`ifdef SR_READBACK_CMP_EN
            mismatch   <= 1'b0;
`endif
        end else begin
            capture_sr <= 1'b0;
            valid      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= CAPTURE;
                        capture_sr <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                CAPTURE: begin
                    state    <= SHIFT;
                    count    <= '0;
                    shift_en <= 1'b1;
                end
                SHIFT: begin
                    shift_q <= shift_d;
                    if (count == LAST) begin
                        state    <= DONE;
                        shift_en <= 1'b0;
                        valid    <= 1'b1;
                        dout     <= word;
`ifdef SR_READBACK_CMP_EN
                        mismatch <= (word != expected);
`endif
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    shift_en <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_readback_ctrl.sv
// Directed bench for sr_readback_ctrl: two 8-bit instances (MSB/LSB first) and one default 170-bit instance.
// Compile with SR_READBACK_CMP_EN defined to also exercise the compare feature.
module tb_sr_readback_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start8 = 1'b0, din8 = 1'b0;
    logic         cap_a, sh_a, busy_a, val_a;
    logic         cap_b, sh_b, busy_b, val_b;
    logic [7:0]   dout_a, dout_b;
    logic         start_c = 1'b0, din_c = 1'b0;
    logic         cap_c, sh_c, busy_c, val_c;
    logic [169:0] dout_c;
`ifdef SR_READBACK_CMP_EN
    logic [7:0]   exp_a = 8'h00;
    logic [7:0]   exp_b = 8'h00;
    logic [169:0] exp_c = '0;
    logic         mis_a, mis_b, mis_c;
`endif

    int n_cmp = 0;
    int n_err = 0;

    sr_readback_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(4), .SHIFT_DIRECTION(1)) u_msb (
        .clk(clk), .rst(rst), .start(start8), .sr_din(din8),
`ifdef SR_READBACK_CMP_EN
        .expected(exp_a), .mismatch(mis_a),
`endif
        .capture_sr(cap_a), .shift_en(sh_a), .busy(busy_a), .valid(val_a), .dout(dout_a)
    );

    sr_readback_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(4), .SHIFT_DIRECTION(0)) u_lsb (
        .clk(clk), .rst(rst), .start(start8), .sr_din(din8),
`ifdef SR_READBACK_CMP_EN
        .expected(exp_b), .mismatch(mis_b),
`endif
        .capture_sr(cap_b), .shift_en(sh_b), .busy(busy_b), .valid(val_b), .dout(dout_b)
    );

    sr_readback_ctrl u_wide (
        .clk(clk), .rst(rst), .start(start_c), .sr_din(din_c),
`ifdef SR_READBACK_CMP_EN
        .expected(exp_c), .mismatch(mis_c),
`endif
        .capture_sr(cap_c), .shift_en(sh_c), .busy(busy_c), .valid(val_c), .dout(dout_c)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // One 8-bit readback on both narrow instances; bit k of the stream is p[7-k].
    // Inputs change on the falling edge; outputs are sampled there for the cycle in progress.
    task automatic run8(input logic [7:0] p, input bit chk_timing);
        logic [3:0] want;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            start8 = (c == 0);
            din8   = (c >= 2 && c <= 9) ? p[9-c] : 1'b0;
            if (chk_timing) begin
                want = {c == 1, c >= 2 && c <= 9, c == 10, c >= 1 && c <= 10};
                check($sformatf("msb_ctl_c%0d", c), 256'({cap_a, sh_a, val_a, busy_a}), 256'(want));
                check($sformatf("lsb_ctl_c%0d", c), 256'({cap_b, sh_b, val_b, busy_b}), 256'(want));
            end
        end
        check("msb_dout", 256'(dout_a), 256'(p));
        check("lsb_dout", 256'(dout_b), 256'(rev8(p)));
    endtask

    initial begin
        int            n_valid, v1, v2, idle_between, sh_cnt, vc;
        logic [169:0]  want_c;

        // Reset state
        @(negedge clk);
        check("rst_ctl_a", 256'({cap_a, sh_a, val_a, busy_a}), 256'(0));
        check("rst_dout_a", 256'(dout_a), 256'(0));
        check("rst_dout_c", 256'(dout_c), 256'(0));
`ifdef SR_READBACK_CMP_EN
        check("rst_mismatch", 256'(mis_a), 256'(0));
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Scenarios 1 and 2: B2 stream, MSB first -> B2, LSB first -> 4D
        run8(8'hB2, 1'b1);
        check("lsb_dout_4d", 256'(dout_b), 256'(8'h4D));
        run8(8'h6F, 1'b1);

        // Scenario 3a: re-pulses during SHIFT and DONE are ignored
        n_valid = 0;
        for (int c = 0; c <= 25; c++) begin
            @(negedge clk);
            start8 = (c == 0) || (c == 4) || (c == 10);
            din8   = 1'b1;
            if (val_a) n_valid++;
        end
        start8 = 1'b0;
        check("ignore_valids", 256'(n_valid), 256'(1));
        check("ignore_idle", 256'(busy_a), 256'(0));

        // Scenario 3b: start held high -> back-to-back, one IDLE cycle between
        v1 = -1; v2 = -1; idle_between = 0;
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            start8 = 1'b1;
            if (val_a && v1 < 0) v1 = c;
            else if (val_a && v2 < 0) v2 = c;
            if (v1 >= 0 && v2 < 0 && !busy_a) idle_between++;
        end
        start8 = 1'b0;
        check("b2b_first_valid", 256'(v1), 256'(10));
        check("b2b_period", 256'(v2 - v1), 256'(11));
        check("b2b_idle_cycles", 256'(idle_between), 256'(1));
        repeat (14) @(negedge clk);
        check("b2b_drained", 256'(busy_a), 256'(0));

        // Scenario 4: reset at SHIFT cycle 3 after a B2 result
        run8(8'hB2, 1'b0);
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            start8 = (c == 0);
            din8   = 1'b1;
            if (c == 4) check("hold_dout_shift", 256'(dout_a), 256'(8'hB2));
        end
        rst = 1'b1;
        #1;
        check("midrst_ctl_a", 256'({cap_a, sh_a, val_a, busy_a}), 256'(0));
        check("midrst_ctl_b", 256'({cap_b, sh_b, val_b, busy_b}), 256'(0));
        check("midrst_dout_a", 256'(dout_a), 256'(0));
        check("midrst_dout_b", 256'(dout_b), 256'(0));
        @(negedge clk);
        check("midrst_no_valid", 256'(val_a), 256'(0));
        rst = 1'b0;
        start8 = 1'b0;
        @(negedge clk);
        run8(8'h01, 1'b1);

        // Scenario 5: 170-bit alternating stream starting with 1
        for (int k = 0; k < 170; k++) want_c[169-k] = (k % 2 == 0);
        sh_cnt = 0; vc = -1;
        for (int c = 0; c <= 174; c++) begin
            @(negedge clk);
            start_c = (c == 0);
            din_c   = (c >= 2 && c <= 171) ? ((c - 2) % 2 == 0) : 1'b0;
            if (sh_c) sh_cnt++;
            if (val_c && vc < 0) vc = c;
        end
        check("wide_valid_cycle", 256'(vc), 256'(172));
        check("wide_shift_cycles", 256'(sh_cnt), 256'(170));
        check("wide_dout", 256'(dout_c), 256'(want_c));

`ifdef SR_READBACK_CMP_EN
        // Scenario 6: compare against expected word
        exp_a = 8'hB2;
        run8(8'hB2, 1'b0);
        check("cmp_match", 256'(mis_a), 256'(0));
        exp_a = 8'hB3;
        run8(8'hB2, 1'b0);
        check("cmp_mismatch", 256'(mis_a), 256'(1));
        exp_a = 8'hB2;
        repeat (3) @(negedge clk);
        check("cmp_mismatch_hold", 256'(mis_a), 256'(1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
